// File: rtl/exe_div_unit_if.sv
// Interface bundling the divider's RF-side request, pipeline control and
// writeback result signals. The divider connects through the slave modport.
// The master modport is the RF/pipeline side that drives requests.
interface exe_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             stall_in;
    logic             in_en;
    logic [1:0]       in_op;
    logic [4:0]       in_rd;
    logic [WIDTH-1:0] in_src0;
    logic [WIDTH-1:0] in_src1;
    logic             stall_out;
    logic             out_valid;
    logic             out_we;
    logic [4:0]       out_rd;
    logic [WIDTH-1:0] out_data;

    modport master (
        output flush, stall_in, in_en, in_op, in_rd, in_src0, in_src1,
        input  stall_out, out_valid, out_we, out_rd, out_data
    );

    modport slave (
        input  flush, stall_in, in_en, in_op, in_rd, in_src0, in_src1,
        output stall_out, out_valid, out_we, out_rd, out_data
    );
endinterface

// File: rtl/exe_div_unit.sv
// exe_div_unit: multi-cycle radix-2 restoring integer divider for the EXE stage.
// Divides operand magnitudes, then applies the sign fix-up when the result is
// registered. Holds the RF stage via stall_out while an operation is in flight.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when the
// divisor is zero or |dividend| < |divisor|.
module exe_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    exe_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, quotient shifts in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             rem_sel_q, rem_sel_d;
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    // Operand signs and magnitudes; unsigned ops treat the raw value as magnitude.
    logic             sgn0, sgn1;
    logic [WIDTH-1:0] mag0, mag1;
    assign sgn0 = !bus.in_op[1] && bus.in_src0[WIDTH-1];
    assign sgn1 = !bus.in_op[1] && bus.in_src1[WIDTH-1];
    assign mag0 = sgn0 ? -bus.in_src0 : bus.in_src0;
    assign mag1 = sgn1 ? -bus.in_src1 : bus.in_src1;

    // One restoring iteration. A set top bit in the stored remainder would mean
    // the shifted value already exceeds any divisor, so it forces a subtract.
    logic [WIDTH:0]   rem_sh, rem_step;
    logic [WIDTH-1:0] dvd_step;
    logic             ge;
    logic [WIDTH-1:0] quo_fix, rem_fix, result;
    assign rem_sh   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign ge       = rem_q[WIDTH] || (rem_sh >= {1'b0, dvs_q});
    assign rem_step = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    assign dvd_step = {dvd_q[WIDTH-2:0], ge};
    assign quo_fix  = neg_quo_q ? -dvd_step : dvd_step;
    assign rem_fix  = neg_rem_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
    assign result   = rem_sel_q ? rem_fix : quo_fix;

    // Next-state and datapath update; flush overrides everything and leaves
    // the visible result untouched.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        rem_sel_d  = rem_sel_q;
        rd_d       = rd_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_en) begin
                    dvd_d     = mag0;
                    dvs_d     = mag1;
                    rem_d     = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    // Divide-by-zero keeps the all-ones quotient regardless of sign.
                    neg_quo_d = (sgn0 ^ sgn1) && (bus.in_src1 != '0);
                    neg_rem_d = sgn0;
                    rem_sel_d = bus.in_op[0];
                    rd_d      = bus.in_rd;
                    state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (bus.in_src1 == '0) begin
                        state_d    = S_DONE;
                        out_data_d = bus.in_op[0] ? bus.in_src0 : '1;
                        out_rd_d   = bus.in_rd;
                    end else if (mag0 < mag1) begin
                        state_d    = S_DONE;
                        out_data_d = bus.in_op[0] ? bus.in_src0 : '0;
                        out_rd_d   = bus.in_rd;
                    end
`endif
                end
            end
            S_CALC: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                if (cnt_q == '0) begin
                    state_d    = S_DONE;
                    out_data_d = result;
                    out_rd_d   = rd_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.stall_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d    = S_IDLE;
            out_rd_d   = out_rd_q;
            out_data_d = out_data_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
            rd_q       <= '0;
            out_rd_q   <= '0;
            out_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            rem_sel_q  <= rem_sel_d;
            rd_q       <= rd_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
        end
    end

    // stall_out drops in a non-stalled DONE cycle so the RF register advances
    // on the same edge that returns the FSM to IDLE.
    assign bus.stall_out = !bus.flush && (((state_q == S_IDLE) && bus.in_en) ||
                                          (state_q == S_CALC) ||
                                          ((state_q == S_DONE) && bus.stall_in));
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_we    = (state_q == S_DONE) && (out_rd_q != '0);
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;
endmodule
